// File: rtl/dma_tx_chain_credit.sv
// dma_tx_chain_credit: per-chain outstanding-request admission gate in front of the DMA TX mux
// Ports:
//   user_clk, reset_n         clock, asynchronous active-low reset
//   cfg_en, cfg_limit         per-chain admission enable and max outstanding packets (0 blocks)
//   up_tvalid/up_tlast/up_tready  chain source handshake (ready is gated)
//   dn_tvalid/dn_tready       gated handshake toward the multiplexer
//   cpl_valid, cpl_chain      one completion per cycle, returned by the TX/RX tracker
//   out_cnt, chain_busy       outstanding count per chain, mid-packet-or-outstanding flag
//   err_underflow, err_clr    sticky completion-with-zero-count flags and their clear
module dma_tx_chain_credit #(
  parameter int CHAIN_NUM = 4,
  parameter int CNT_W = 6,
  localparam int IDX_W = $clog2(CHAIN_NUM)
) (
  input  logic                 user_clk,
  input  logic                 reset_n,
  input  logic [CHAIN_NUM-1:0] cfg_en,
  input  logic [CNT_W-1:0]     cfg_limit [CHAIN_NUM],
  input  logic [CHAIN_NUM-1:0] up_tvalid,
  input  logic [CHAIN_NUM-1:0] up_tlast,
  output logic [CHAIN_NUM-1:0] up_tready,
  output logic [CHAIN_NUM-1:0] dn_tvalid,
  input  logic [CHAIN_NUM-1:0] dn_tready,
  input  logic                 cpl_valid,
  input  logic [IDX_W-1:0]     cpl_chain,
  output logic [CNT_W-1:0]     out_cnt [CHAIN_NUM],
  output logic [CHAIN_NUM-1:0] chain_busy,
  output logic [CHAIN_NUM-1:0] err_underflow,
  input  logic                 err_clr
);
  typedef enum logic {IDLE, PKT} state_t;
  state_t state_q [CHAIN_NUM];
  state_t state_d [CHAIN_NUM];
  logic [CNT_W-1:0] cnt_nxt [CHAIN_NUM];
  logic [CHAIN_NUM-1:0] admit_q, open_g, hs, inc, dec, uflow;
  always_comb begin
    for (int c = 0; c < CHAIN_NUM; c++) begin
      // once a packet has started the gate stays open until its tlast
      open_g[c] = state_q[c] == PKT || admit_q[c];
      dn_tvalid[c] = up_tvalid[c] && open_g[c];
      up_tready[c] = dn_tready[c] && open_g[c];
      hs[c] = up_tvalid[c] && dn_tready[c] && open_g[c];
      inc[c] = hs[c] && up_tlast[c];
      dec[c] = cpl_valid && cpl_chain == IDX_W'(c);
      uflow[c] = dec[c] && !inc[c] && out_cnt[c] == '0;
      // a completion at count 0 is void, so a coincident increment still lands
      cnt_nxt[c] = (inc[c] && (!dec[c] || out_cnt[c] == '0))
                   ? (out_cnt[c] == {CNT_W{1'b1}} ? out_cnt[c] : out_cnt[c] + CNT_W'(1))
                   : (dec[c] && !inc[c] && out_cnt[c] != '0) ? out_cnt[c] - CNT_W'(1) : out_cnt[c];
      state_d[c] = !hs[c] ? state_q[c] : (up_tlast[c] ? IDLE : PKT);
      chain_busy[c] = state_q[c] == PKT || out_cnt[c] != '0;
    end
  end
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHAIN_NUM; c++) begin
        state_q[c] <= IDLE;
        out_cnt[c] <= '0;
      end
      admit_q <= '0;
      err_underflow <= '0;
    end else begin
      for (int c = 0; c < CHAIN_NUM; c++) begin
        state_q[c] <= state_d[c];
        out_cnt[c] <= cnt_nxt[c];
        // admission judged against the count being loaded now, so a chain hitting its limit closes next cycle
        admit_q[c] <= cfg_en[c] && cnt_nxt[c] < cfg_limit[c];
        err_underflow[c] <= uflow[c] || (err_underflow[c] && !err_clr);
      end
    end
  end
endmodule

// File: tb/tb_dma_tx_chain_credit.sv
// tb_dma_tx_chain_credit: directed and randomized check of dma_tx_chain_credit against a packet-level model
module tb_dma_tx_chain_credit;
  localparam int N = 4;
  localparam int W = 6;
  logic user_clk = 0;
  logic reset_n = 0;
  logic [N-1:0] cfg_en, up_tvalid, up_tlast, up_tready, dn_tvalid, dn_tready, chain_busy, err_underflow;
  logic [W-1:0] cfg_limit [N];
  logic [W-1:0] out_cnt [N];
  logic cpl_valid, err_clr;
  logic [1:0] cpl_chain;
  int errors = 0;
  int checks = 0;
  int m_cnt [N];
  int beat [N];
  int len [N];
  int acc_n [N];
  bit m_pkt [N];
  bit m_adm [N];
  bit m_err [N];
  bit m_open [N];
  always #5 user_clk = ~user_clk;
  dma_tx_chain_credit #(.CHAIN_NUM(N), .CNT_W(W)) dut (
    .user_clk(user_clk), .reset_n(reset_n), .cfg_en(cfg_en), .cfg_limit(cfg_limit),
    .up_tvalid(up_tvalid), .up_tlast(up_tlast), .up_tready(up_tready),
    .dn_tvalid(dn_tvalid), .dn_tready(dn_tready), .cpl_valid(cpl_valid), .cpl_chain(cpl_chain),
    .out_cnt(out_cnt), .chain_busy(chain_busy), .err_underflow(err_underflow), .err_clr(err_clr)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_cnt[c] = 0;
      m_pkt[c] = 0;
      m_adm[c] = 0;
      m_err[c] = 0;
      beat[c] = 0;
    end
  endtask
  // one clock: present tlast, check outputs mid-cycle, then advance the model past the edge
  task automatic step();
    @(negedge user_clk);
    for (int c = 0; c < N; c++) up_tlast[c] = (beat[c] == len[c] - 1);
    #1;
    for (int c = 0; c < N; c++) begin
      m_open[c] = m_pkt[c] || m_adm[c];
      chk($sformatf("dn_tvalid[%0d]", c), dn_tvalid[c], up_tvalid[c] && m_open[c]);
      chk($sformatf("up_tready[%0d]", c), up_tready[c], dn_tready[c] && m_open[c]);
      chk($sformatf("out_cnt[%0d]", c), out_cnt[c], m_cnt[c]);
      chk($sformatf("chain_busy[%0d]", c), chain_busy[c], m_pkt[c] || m_cnt[c] != 0);
      chk($sformatf("err_underflow[%0d]", c), err_underflow[c], m_err[c]);
    end
    @(posedge user_clk);
    #1;
    if (!reset_n) model_reset();
    else for (int c = 0; c < N; c++) begin
      int nc;
      bit done, uf;
      done = 0;
      uf = 0;
      if (up_tvalid[c] && dn_tready[c] && m_open[c]) begin
        acc_n[c]++;
        done = up_tlast[c];
        m_pkt[c] = !up_tlast[c];
        beat[c] = up_tlast[c] ? 0 : beat[c] + 1;
      end
      nc = m_cnt[c];
      if (cpl_valid && cpl_chain == c) begin
        if (nc > 0) nc--;
        else if (!done) uf = 1;
      end
      if (done && nc < 63) nc++;
      m_cnt[c] = nc;
      m_err[c] = uf || (m_err[c] && !err_clr);
      m_adm[c] = cfg_en[c] && m_cnt[c] < cfg_limit[c];
    end
  endtask
  task automatic pulse_reset();
    reset_n = 0;
    #1;
    for (int c = 0; c < N; c++) begin
      chk($sformatf("rst_dn_tvalid[%0d]", c), dn_tvalid[c], 0);
      chk($sformatf("rst_up_tready[%0d]", c), up_tready[c], 0);
      chk($sformatf("rst_out_cnt[%0d]", c), out_cnt[c], 0);
      chk($sformatf("rst_busy[%0d]", c), chain_busy[c], 0);
      chk($sformatf("rst_err[%0d]", c), err_underflow[c], 0);
    end
    model_reset();
    step();
    step();
    reset_n = 1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    cfg_en = '0;
    up_tvalid = '0;
    up_tlast = '0;
    dn_tready = '0;
    cpl_valid = 0;
    cpl_chain = 0;
    err_clr = 0;
    for (int c = 0; c < N; c++) begin
      cfg_limit[c] = '0;
      len[c] = 1;
      acc_n[c] = 0;
    end
    model_reset();
    step();
    step();
    reset_n = 1;
    // chain 0: limit 2, three back-to-back 4-beat packets
    cfg_en[0] = 1;
    cfg_limit[0] = 2;
    len[0] = 4;
    up_tvalid[0] = 1;
    dn_tready[0] = 1;
    repeat (14) step();
    chk("s1_beats", acc_n[0], 8);
    chk("s1_cnt", out_cnt[0], 2);
    chk("s1_closed", dn_tvalid[0], 0);
    // a completion reopens the chain one cycle later
    cpl_valid = 1;
    cpl_chain = 0;
    step();
    cpl_valid = 0;
    chk("s2_cnt", out_cnt[0], 1);
    chk("s2_open", up_tready[0], 1);
    step();
    chk("s2_beat", acc_n[0], 9);
    repeat (3) step();
    up_tvalid[0] = 0;
    chk("s2_done_beats", acc_n[0], 12);
    chk("s2_done_cnt", out_cnt[0], 2);
    // chain 1: single-beat packets with coincident completions
    cfg_en[1] = 1;
    cfg_limit[1] = 1;
    len[1] = 1;
    dn_tready[1] = 1;
    step();
    up_tvalid[1] = 1;
    cpl_valid = 1;
    cpl_chain = 1;
    step();
    cpl_valid = 0;
    up_tvalid[1] = 0;
    chk("s3_zero_inc_cnt", out_cnt[1], 1);
    chk("s3_zero_inc_err", err_underflow[1], 0);
    cfg_limit[1] = 2;
    step();
    up_tvalid[1] = 1;
    cpl_valid = 1;
    step();
    cpl_valid = 0;
    up_tvalid[1] = 0;
    chk("s3_net_zero", out_cnt[1], 1);
    chk("s3_idle_busy", chain_busy[1], 1);
    // chain 2: enable dropped during beat 2 of a 5-beat packet, ready toggling
    cfg_en[2] = 1;
    cfg_limit[2] = 3;
    len[2] = 5;
    up_tvalid[2] = 1;
    dn_tready[2] = 1;
    for (int k = 0; k < 40 && acc_n[2] < 5; k++) begin
      if (beat[2] == 1) cfg_en[2] = 0;
      step();
      dn_tready[2] = ~dn_tready[2];
    end
    chk("s4_beats", acc_n[2], 5);
    dn_tready[2] = 1;
    repeat (6) step();
    chk("s4_blocked", acc_n[2], 5);
    chk("s4_busy", chain_busy[2], 1);
    cpl_valid = 1;
    cpl_chain = 2;
    step();
    cpl_valid = 0;
    up_tvalid[2] = 0;
    chk("s4_idle", chain_busy[2], 0);
    // chain 3: underflow, clear colliding with a new underflow, then a plain clear
    cpl_valid = 1;
    cpl_chain = 3;
    step();
    cpl_valid = 0;
    chk("s5_err_set", err_underflow[3], 1);
    chk("s5_cnt_zero", out_cnt[3], 0);
    cpl_valid = 1;
    err_clr = 1;
    step();
    cpl_valid = 0;
    chk("s5_err_held", err_underflow[3], 1);
    step();
    err_clr = 0;
    chk("s5_err_clr", err_underflow[3], 0);
    // all chains randomized, limits 1..4, reset pulsed mid-traffic
    for (int c = 0; c < N; c++) begin
      cfg_limit[c] = W'(c + 1);
      len[c] = c + 2;
    end
    pulse_reset();
    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < N; c++) begin
        up_tvalid[c] = $urandom_range(0, 3) != 0;
        dn_tready[c] = 1'($urandom_range(0, 1));
        cfg_en[c] = $urandom_range(0, 7) != 0;
      end
      cpl_valid = $urandom_range(0, 2) == 0;
      cpl_chain = 2'($urandom_range(0, 3));
      err_clr = $urandom_range(0, 15) == 0;
      step();
      for (int c = 0; c < N; c++) chk($sformatf("limit[%0d]", c), out_cnt[c] <= cfg_limit[c], 1);
      if (k == 200) pulse_reset();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
